imm_pack: RTL and testbench

// - Inverse of the decode-side immediate extender: packs a 32-bit immediate into instruction bit positions per format (I/S/B/J/U), overlaying a base word.
// - Sits in the instruction-generation/self-test path; round trip: extend(fmt, imm_pack(fmt, imm, base)) == imm for every legal input.
// - 2-stage valid/ready pipeline with legality checking (range, alignment, format) and a saturating error counter.

---
 rtl/imm_pack_pkg.sv | 47 ++++
 rtl/imm_pack_if.sv | 30 +++
 rtl/imm_pack_core.sv | 54 +++++
 rtl/imm_pack.sv | 87 ++++++++
 tb/tb_imm_pack.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pack_pkg.sv
// Shared definitions for the immediate packer: format and error codes,
// field widths, and the sign-run test used by the legality checks.
package imm_pack_pkg;

    localparam int INST_W = 32;
    localparam int IMM_W  = 32;
    localparam int FMT_W  = 3;
    localparam int ERR_W  = 2;

    // Instruction formats, identical to the decode-side extender encoding.
    typedef enum logic [FMT_W-1:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100
    } fmt_e;

    // Legality result; larger code wins when several problems coexist.
    typedef enum logic [ERR_W-1:0] {
        ERR_OK    = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_FMT   = 2'b11
    } err_e;

    // Bits of the instruction word owned by the immediate in each format.
    localparam logic [INST_W-1:0] MASK_I = 32'hFFF0_0000;
    localparam logic [INST_W-1:0] MASK_S = 32'hFE00_0F80;
    localparam logic [INST_W-1:0] MASK_B = 32'hFE00_0F80;
    localparam logic [INST_W-1:0] MASK_J = 32'hFFFF_F000;
    localparam logic [INST_W-1:0] MASK_U = 32'hFFFF_F000;

    // True when imm[IMM_W-1:msb] are all copies of the sign bit, i.e. the
    // value survives truncation to msb+1 bits and sign extension back.
    function automatic logic sign_run_ok(input logic [IMM_W-1:0] imm, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < IMM_W; i++) begin
            if (i >= msb && imm[i] != imm[IMM_W-1]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Handshake bundle for the immediate packer: request channel (fmt/imm/base)
// and response channel (inst/err), each with its own valid/ready pair.
interface imm_pack_if
    import imm_pack_pkg::*;
    ;

    logic                     in_valid;
    logic                     in_ready;
    logic [FMT_W-1:0]         in_fmt;
    logic signed [IMM_W-1:0]  in_imm;
    logic [INST_W-1:0]        in_base;

    logic                     out_valid;
    logic                     out_ready;
    logic [INST_W-1:0]        out_inst;
    logic [ERR_W-1:0]         out_err;

    // Producer of requests and consumer of responses.
    modport master (
        output in_valid, in_fmt, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    // The packer itself.
    modport slave (
        input  in_valid, in_fmt, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

endinterface

// File: rtl/imm_pack_core.sv
// Combinational packer: scatters immediate bits into their instruction
// positions over a base word and classifies the immediate's legality.
// Illegal immediates are still packed (truncated) so the word is usable.
module imm_pack_core
    import imm_pack_pkg::*;
(
    input  logic [FMT_W-1:0]        fmt,
    input  logic signed [IMM_W-1:0] imm,
    input  logic [INST_W-1:0]       base,
    output logic [INST_W-1:0]       inst,
    output logic [ERR_W-1:0]        err
);

    // Field placement and legality per format; unknown formats pass base through.
    always_comb begin
        inst = base;
        err  = ERR_OK;
        case (fmt)
            FMT_I: begin
                inst[31:20] = imm[11:0];
                if (!sign_run_ok(imm, 11)) err = ERR_RANGE;
            end
            FMT_S: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                if (!sign_run_ok(imm, 11)) err = ERR_RANGE;
            end
            FMT_B: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                if (imm[0])                      err = ERR_ALIGN;
                else if (!sign_run_ok(imm, 12))  err = ERR_RANGE;
            end
            FMT_J: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                if (imm[0])                      err = ERR_ALIGN;
                else if (!sign_run_ok(imm, 20))  err = ERR_RANGE;
            end
            FMT_U: begin
                inst[31:12] = imm[31:12];
                if (imm[11:0] != 12'h000) err = ERR_RANGE;
            end
            default: begin
                err = ERR_FMT;
            end
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready wrapper around imm_pack_core. Stage 1 holds the
// accepted request, stage 2 holds the packed word and its error code, and a
// saturating counter tallies delivered beats that carried an error.
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    imm_pack_if.slave        bus,
    output logic [CNT_W-1:0] err_cnt
);

    logic                     vld_p1;
    logic                     vld_p2;
    logic                     adv_p1;
    logic                     adv_p2;

    logic [FMT_W-1:0]         fmt_p1;
    logic signed [IMM_W-1:0]  imm_p1;
    logic [INST_W-1:0]        base_p1;

    logic [INST_W-1:0]        core_inst;
    logic [ERR_W-1:0]         core_err;

    logic [INST_W-1:0]        inst_p2;
    logic [ERR_W-1:0]         err_p2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage 2 frees up when empty or draining; stage 1 when empty or stage 2 frees.
    assign adv_p2       = !vld_p2 || bus.out_ready;
    assign adv_p1       = !vld_p1 || adv_p2;
    assign bus.in_ready = adv_p1;

    // Control: valid bits and the saturating error tally.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (adv_p1) vld_p1 <= bus.in_valid;
            if (adv_p2) vld_p2 <= vld_p1;
            if (vld_p2 && bus.out_ready && (err_p2 != ERR_OK)) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    // ---- input -> stage 1: capture the accepted request ----
    always_ff @(posedge clk) begin
        if (adv_p1 && bus.in_valid) begin
            fmt_p1  <= bus.in_fmt;
            imm_p1  <= bus.in_imm;
            base_p1 <= bus.in_base;
        end
    end

    // ---- stage 1 -> stage 2: packing and legality resolved from the held request ----
    imm_pack_core u_core (
        .fmt  (fmt_p1),
        .imm  (imm_p1),
        .base (base_p1),
        .inst (core_inst),
        .err  (core_err)
    );

    // Stage 2 output registers; cleared on reset so the idle bus reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_p2 <= '0;
            err_p2  <= ERR_OK;
        end else if (adv_p2 && vld_p1) begin
            inst_p2 <= core_inst;
            err_p2  <= core_err;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_inst  = inst_p2;
    assign bus.out_err   = err_p2;

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: directed cases, backpressure, reset mid-stream,
// counter saturation and a long randomized round trip against a reference
// packer/extender written with plain arithmetic.
module tb_imm_pack;

    logic       clk;
    logic       rst;
    logic [7:0] err_cnt;

    imm_pack_if bus ();

    imm_pack #(.CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] inst;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          total_errs = 0;
    bit          last_acc;
    logic        last_in_ready;
    logic        last_out_valid;
    logic [31:0] last_out_inst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference packer: legality from numeric ranges, placement from shifts/masks.
    function automatic void model(input logic [2:0] f, input logic [31:0] imm, input logic [31:0] base,
                                  output logic [31:0] inst, output logic [1:0] err);
        longint      s;
        logic [31:0] mask;
        logic [31:0] put;
        bit          in_range;
        bit          aligned;
        s        = longint'($signed(imm));
        mask     = 32'h0;
        put      = 32'h0;
        in_range = 1'b1;
        aligned  = 1'b1;
        case (f)
            3'd0: begin
                in_range = (s >= -2048) && (s <= 2047);
                mask = 32'hFFF0_0000;
                put  = (imm & 32'hFFF) << 20;
            end
            3'd1: begin
                in_range = (s >= -2048) && (s <= 2047);
                mask = 32'hFE00_0F80;
                put  = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd2: begin
                in_range = (s >= -4096) && (s <= 4095);
                aligned  = (imm % 2) == 0;
                mask = 32'hFE00_0F80;
                put  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            end
            3'd3: begin
                in_range = (s >= -1048576) && (s <= 1048575);
                aligned  = (imm % 2) == 0;
                mask = 32'hFFFF_F000;
                put  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            end
            3'd4: begin
                in_range = (imm % 4096) == 0;
                mask = 32'hFFFF_F000;
                put  = imm & 32'hFFFF_F000;
            end
            default: ;
        endcase
        if (f > 3'd4) begin
            inst = base;
            err  = 2'b11;
        end else begin
            inst = (base & ~mask) | put;
            err  = !aligned ? 2'b10 : (!in_range ? 2'b01 : 2'b00);
        end
    endfunction

    // Decode-side extender: recovers the immediate from an instruction word.
    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] w);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [31:0] r;
        r = 32'sd0;
        case (f)
            3'd0: begin i12 = w[31:20];                                      r = i12; end
            3'd1: begin i12 = {w[31:25], w[11:7]};                           r = i12; end
            3'd2: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};        r = b13; end
            3'd3: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};      r = j21; end
            3'd4: begin r = $signed({w[31:12], 12'h000}); end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] cnt_expect();
        return (total_errs > 255) ? 32'd255 : 32'(total_errs);
    endfunction

    task automatic gen_legal(output logic [2:0] f, output logic [31:0] imm);
        int v;
        f = 3'($urandom_range(0, 4));
        case (f)
            3'd0, 3'd1: begin v = int'($urandom_range(0, 4095)) - 2048;        imm = 32'(v); end
            3'd2:       begin v = int'($urandom_range(0, 4095)) - 2048;        imm = 32'(v * 2); end
            3'd3:       begin v = int'($urandom_range(0, 1048575)) - 524288;   imm = 32'(v * 2); end
            default:    begin imm = $urandom & 32'hFFFF_F000; end
        endcase
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] imm,
                         input logic [31:0] base, input logic rdy);
        bus.in_valid  = v;
        bus.in_fmt    = f;
        bus.in_imm    = imm;
        bus.in_base   = base;
        bus.out_ready = rdy;
    endtask

    // One clock: sample settled handshakes, score drained beats, log accepted ones.
    task automatic step();
        exp_t e;
        #1;
        last_in_ready  = bus.in_ready;
        last_out_valid = bus.out_valid;
        last_out_inst  = bus.out_inst;
        last_acc       = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("stray_beat", 32'(bus.out_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst", bus.out_inst, e.inst);
                chk("sb_err", 32'(bus.out_err), 32'(e.err));
                if (e.err == 2'b00) chk("round_trip", extend(e.fmt, bus.out_inst), e.imm);
                if (e.err != 2'b00) total_errs++;
            end
        end
        if (last_acc) begin
            e.fmt = bus.in_fmt;
            e.imm = bus.in_imm;
            model(bus.in_fmt, bus.in_imm, bus.in_base, e.inst, e.err);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [2:0] f, input logic [31:0] imm,
                            input logic [31:0] base, input logic [31:0] exp_inst, input logic [1:0] exp_err);
        drive(1'b1, f, imm, base, 1'b1);
        step();
        chk({tag, "_accept"}, 32'(last_acc), 32'h1);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'h0);
        step();
        chk({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'h1);
        chk({tag, "_inst"}, bus.out_inst, exp_inst);
        chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] a_inst;
        logic [1:0]  a_err;
        logic [2:0]  bf[4];
        logic [31:0] bi[4];
        logic [31:0] bb[4];
        logic        ir[12];
        logic        ov[12];
        logic [31:0] oi[12];
        bit [11:0]   rdy_pat;
        bit [4:0]    exp_ir;
        int          k;
        int          sent;
        bit          pending;

        // Reset state
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_out_err", 32'(bus.out_err), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Directed formats
        directed("i_min", 3'b000, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 2'b00);
        directed("j_range", 3'b011, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 2'b01);
        directed("bad_fmt", 3'b110, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11);
        chk("cnt_after_j_fmt", 32'(err_cnt), 32'd2);
        directed("b_max", 3'b010, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 2'b00);
        directed("b_misalign", 3'b010, 32'h0000_1001, 32'h0000_0063, 32'h8000_0063, 2'b10);
        chk("cnt_after_b", 32'(err_cnt), 32'd3);

        // Backpressure: four beats back to back, out_ready low for three cycles
        for (int i = 0; i < 4; i++) begin
            gen_legal(bf[i], bi[i]);
            bb[i] = $urandom;
        end
        model(bf[0], bi[0], bb[0], a_inst, a_err);
        rdy_pat = 12'b1111_1111_0001;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (k < 4) drive(1'b1, bf[k], bi[k], bb[k], rdy_pat[c]);
            else       drive(1'b0, 3'd0, 32'h0, 32'h0, rdy_pat[c]);
            step();
            ir[c] = last_in_ready;
            ov[c] = last_out_valid;
            oi[c] = last_out_inst;
            if (last_acc) k++;
        end
        exp_ir = 5'b10011;
        for (int c = 0; c < 5; c++) chk($sformatf("bp_in_ready_c%0d", c), 32'(ir[c]), 32'(exp_ir[c]));
        chk("bp_hold_valid_c2", 32'(ov[2]), 32'h1);
        chk("bp_hold_valid_c3", 32'(ov[3]), 32'h1);
        chk("bp_hold_inst_c2", oi[2], a_inst);
        chk("bp_hold_inst_c3", oi[3], a_inst);
        chk("bp_accepted", 32'(k), 32'd4);
        chk("bp_all_delivered", 32'(exp_q.size()), 32'd0);

        // Random legal round trip
        sent = 0;
        pending = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            if (!pending && ($urandom % 4) != 0) begin
                gen_legal(f, imm);
                bus.in_valid = 1'b1;
                bus.in_fmt   = f;
                bus.in_imm   = imm;
                bus.in_base  = $urandom;
                pending      = 1'b1;
            end
            bus.out_ready = ($urandom % 4) != 0;
            step();
            if (last_acc) begin
                pending      = 1'b0;
                bus.in_valid = 1'b0;
                sent++;
            end
        end
        chk("rt_sent", 32'(sent), 32'd10000);

        // Random mix including illegal immediates and formats
        for (int n = 0; n < 500; n++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom % 3)
                0:       imm = $urandom;
                1:       imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                default: imm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
            endcase
            base = $urandom;
            for (int w = 0; w < 20; w++) begin
                drive(1'b1, f, imm, base, ($urandom % 3) != 0);
                step();
                if (last_acc) break;
            end
            bus.in_valid = 1'b0;
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
            step();
        end
        chk("mix_drained", 32'(exp_q.size()), 32'd0);
        chk("mix_err_cnt", 32'(err_cnt), cnt_expect());

        // Reset with two beats in flight
        drive(1'b1, 3'b111, 32'h0, 32'hCAFE_F00D, 1'b0);
        step();
        step();
        chk("mid_rst_two_in", 32'(exp_q.size()), 32'd2);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
        exp_q.delete();
        total_errs = 0;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("after_rst_no_stale", 32'(bus.out_valid), 32'h0);
        end

        // Error counter saturation
        for (int n = 0; n < 270; n++) begin
            drive(1'b1, 3'b101, $urandom, $urandom, 1'b1);
            step();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
            step();
        end
        chk("sat_drained", 32'(exp_q.size()), 32'd0);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        chk("sat_err_cnt_model", 32'(err_cnt), cnt_expect());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
